// File: rtl/fp_mul_pkg.sv
// Shared definitions for the floating-point multiplier datapath: default
// mantissa width, adder width, FSM encoding and the counter width helper.
package fp_mul_pkg;

  // Mantissa width of a single-precision value including the hidden bit.
  localparam int MANT_W = 24;

  // Width of the carry-lookahead adder used for partial-product accumulation.
  localparam int ADD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for a WIDTH-step iteration: ceil(log2(WIDTH)), never below 1.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/CLA.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups whose group
// carries are chained. Pure combinational.
module CLA (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        iniC,
  output logic [31:0] Sum,
  output logic        Carry
);

  logic [31:0] gen;
  logic [31:0] prop;

  assign gen  = A & B;
  assign prop = A ^ B;

  // Lookahead carries within each nibble, group carry passed to the next nibble.
  always_comb begin
    logic [32:0] c;
    int          b;
    // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
    c    = '0;
    b    = 0;
    c[0] = iniC;
    for (int k = 0; k < 8; k++) begin
      b = 4 * k;
      c[b+1] = gen[b]   | (prop[b] & c[b]);
      c[b+2] = gen[b+1] | (prop[b+1] & gen[b]) | (prop[b+1] & prop[b] & c[b]);
      c[b+3] = gen[b+2] | (prop[b+2] & gen[b+1]) | (prop[b+2] & prop[b+1] & gen[b])
             | (prop[b+2] & prop[b+1] & prop[b] & c[b]);
      c[b+4] = gen[b+3] | (prop[b+3] & gen[b+2]) | (prop[b+3] & prop[b+2] & gen[b+1])
             | (prop[b+3] & prop[b+2] & prop[b+1] & gen[b])
             | (prop[b+3] & prop[b+2] & prop[b+1] & prop[b] & c[b]);
    end
    Sum   = prop ^ c[31:0];
    Carry = c[32];
  end

endmodule

// File: rtl/fp_mant_mul_seq.sv
// Sequential radix-2 shift-add multiplier for unsigned mantissas (hidden bit
// included). One operand pair in flight; full 2*WIDTH-bit product out.
module fp_mant_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int WIDTH = MANT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic                 out_msb
);

  // Derived from WIDTH; large enough to count WIDTH-1.
  localparam int CNT_W = cnt_w(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] mplr;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] addend;
  logic [ADD_W-1:0] add_a;
  logic [ADD_W-1:0] add_b;
  logic [ADD_W-1:0] add_sum;
  logic             add_carry;
  logic [WIDTH-1:0] s;
  logic             c;

  // Partial product for this step: multiplicand gated by the current multiplier LSB.
  assign addend = mplr[0] ? mcand : '0;
  assign add_a  = ADD_W'(acc_hi);
  assign add_b  = ADD_W'(addend);

  CLA u_cla (
    .A     (add_a),
    .B     (add_b),
    .iniC  (1'b0),
    .Sum   (add_sum),
    .Carry (add_carry)
  );

  assign s = add_sum[WIDTH-1:0];

  // The carry out of a WIDTH-bit add lands in Sum[WIDTH] for narrow
  // mantissas and in the adder's own Carry when the full 32 bits are used.
  if (WIDTH < ADD_W) begin : g_narrow
    logic unused_add;
    assign c          = add_sum[WIDTH];
    assign unused_add = ^{add_carry, add_sum[ADD_W-1:WIDTH]};
  end else begin : g_full
    assign c = add_carry;
  end

  assign out_prod = {acc_hi, mplr};
  assign out_msb  = acc_hi[WIDTH-1];

  // Control FSM plus accumulator/shift register and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register, datapath included, is cleared so out_prod reads 0 straight out of reset.
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mcand     <= '0;
      acc_hi    <= '0;
      mplr      <= '0;
      cnt       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= in_a;
            acc_hi   <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (in_a == '0 || in_b == '0) begin
              // Zero operand: product is known, skip the iteration entirely.
              mplr      <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              mplr  <= in_b;
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc_hi <= {c, s[WIDTH-1:1]};
          mplr   <= {s[0], mplr[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mant_mul_seq.sv
// Directed testbench for fp_mant_mul_seq at the default 24-bit mantissa width.
module tb_fp_mant_mul_seq;

  localparam int W = 24;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_prod;
  logic           out_msb;

  int n_checks = 0;
  int n_fail   = 0;

  fp_mant_mul_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_msb   (out_msb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Present one operand pair, return edges from accept until out_valid is
  // seen (1 = rose on the accepting edge) and whether in_ready stayed low.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output logic busy_ok);
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    lat      = 1;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_prod !== 48'h0) begin n_fail++; $display("FAIL reset_out_prod: got %h want 0", out_prod); end
    n_checks++; if (out_msb !== 1'b0) begin n_fail++; $display("FAIL reset_out_msb: got %b want 0", out_msb); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unity();
    int   lat;
    logic busy_ok;
    out_ready = 1'b1;
    do_op(24'h800000, 24'h800000, lat, busy_ok);
    n_checks++; if (lat !== 25) begin n_fail++; $display("FAIL unity_latency: got %0d want 25", lat); end
    n_checks++; if (out_prod !== 48'h400000000000) begin n_fail++; $display("FAIL unity_prod: got %h want 400000000000", out_prod); end
    n_checks++; if (out_msb !== 1'b0) begin n_fail++; $display("FAIL unity_msb: got %b want 0", out_msb); end
    n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL unity_busy_ready: in_ready rose while busy"); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL unity_valid_held_once: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL unity_ready_back: got %b want 1", in_ready); end
  endtask

  task automatic test_max();
    int   lat;
    logic busy_ok;
    out_ready = 1'b1;
    do_op(24'hFFFFFF, 24'hFFFFFF, lat, busy_ok);
    n_checks++; if (lat !== 25) begin n_fail++; $display("FAIL max_latency: got %0d want 25", lat); end
    n_checks++; if (out_prod !== 48'hFFFFFE000001) begin n_fail++; $display("FAIL max_prod: got %h want fffffe000001", out_prod); end
    n_checks++; if (out_msb !== 1'b1) begin n_fail++; $display("FAIL max_msb: got %b want 1", out_msb); end
    @(posedge clk); #1;
  endtask

  task automatic test_asym();
    int   lat;
    logic busy_ok;
    out_ready = 1'b1;
    do_op(24'h800000, 24'hFFFFFF, lat, busy_ok);
    n_checks++; if (out_prod !== 48'h7FFFFF800000) begin n_fail++; $display("FAIL asym_prod: got %h want 7fffff800000", out_prod); end
    n_checks++; if (out_msb !== 1'b0) begin n_fail++; $display("FAIL asym_msb: got %b want 0", out_msb); end
    @(posedge clk); #1;
    do_op(24'hFFFFFF, 24'h800000, lat, busy_ok);
    n_checks++; if (out_prod !== 48'h7FFFFF800000) begin n_fail++; $display("FAIL asym_swap_prod: got %h want 7fffff800000", out_prod); end
    n_checks++; if (lat !== 25) begin n_fail++; $display("FAIL asym_swap_latency: got %0d want 25", lat); end
    @(posedge clk); #1;
    do_op(24'hC00000, 24'hA00001, lat, busy_ok);
    n_checks++; if (out_prod !== 48'h780000C00000) begin n_fail++; $display("FAIL mixed_prod: got %h want 780000c00000", out_prod); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int   lat;
    logic busy_ok;
    out_ready = 1'b1;
    do_op(24'h000000, 24'hABCDEF, lat, busy_ok);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL zero_a_latency: got %0d want 1", lat); end
    n_checks++; if (out_prod !== 48'h0) begin n_fail++; $display("FAIL zero_a_prod: got %h want 0", out_prod); end
    @(posedge clk); #1;
    do_op(24'h123456, 24'h000000, lat, busy_ok);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL zero_b_latency: got %0d want 1", lat); end
    n_checks++; if (out_prod !== 48'h0) begin n_fail++; $display("FAIL zero_b_prod: got %h want 0", out_prod); end
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready_back: got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    int   lat;
    logic busy_ok;
    int   bad_valid, bad_prod, bad_ready;
    out_ready = 1'b0;
    do_op(24'hFFFFFF, 24'hFFFFFF, lat, busy_ok);
    n_checks++; if (lat !== 25) begin n_fail++; $display("FAIL bp_latency: got %0d want 25", lat); end
    bad_valid = 0; bad_prod = 0; bad_ready = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 24'h000001;
      in_b     = 24'h000001;
      @(posedge clk); #1;
      if (out_valid !== 1'b1) bad_valid++;
      if (out_prod !== 48'hFFFFFE000001) bad_prod++;
      if (in_ready !== 1'b0) bad_ready++;
    end
    n_checks++; if (bad_valid != 0) begin n_fail++; $display("FAIL bp_valid_held: %0d cycles dropped, want 0", bad_valid); end
    n_checks++; if (bad_prod != 0) begin n_fail++; $display("FAIL bp_prod_stable: %0d cycles changed, last %h want fffffe000001", bad_prod, out_prod); end
    n_checks++; if (bad_ready != 0) begin n_fail++; $display("FAIL bp_ready_low: %0d cycles high, want 0", bad_ready); end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single_transfer: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_after: got %b want 1", in_ready); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_stray_accept: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int   lat;
    logic busy_ok;
    int   stray;
    out_ready = 1'b1;
    @(negedge clk);
    in_a = 24'hFFFFFF; in_b = 24'hFFFFFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    n_checks++; if (out_prod !== 48'h0) begin n_fail++; $display("FAIL midrst_prod: got %h want 0", out_prod); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stray++;
    end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL midrst_no_pulse: %0d bad cycles, want 0", stray); end
    do_op(24'hC00000, 24'hC00000, lat, busy_ok);
    n_checks++; if (lat !== 25) begin n_fail++; $display("FAIL postrst_latency: got %0d want 25", lat); end
    n_checks++; if (out_prod !== 48'h900000000000) begin n_fail++; $display("FAIL postrst_prod: got %h want 900000000000", out_prod); end
    n_checks++; if (out_msb !== 1'b1) begin n_fail++; $display("FAIL postrst_msb: got %b want 1", out_msb); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_unity();
    test_max();
    test_asym();
    test_zero();
    test_backpressure();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
